// File: rtl/samp_timing_gen.sv
// Sampling-clock sequencer: programmable frame period / track width, continuous or triggered.
// Define SAMP_FRAME_CNT_EN to add the 16-bit frame_cnt output (counts conv_start strobes).
module samp_timing_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             single_shot,
  input  logic             trig,
  input  logic [CNT_W-1:0] samp_period,
  input  logic [CNT_W-1:0] samp_width,
  output logic             samp_clk,
  output logic             conv_start,
  output logic             busy,
  output logic             cfg_err
`ifdef SAMP_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [CNT_W-1:0] r_per, w_per_n;
  logic [CNT_W-1:0] r_wid, w_wid_n;
  logic             r_samp_clk, w_samp_clk_n;
  logic             r_conv_start, w_conv_start_n;
  logic             r_busy, w_busy_n;
  logic             r_cfg_err, w_cfg_err_n;
  logic             w_legal;
  logic             w_continue;
  logic             w_start;

  assign w_legal    = (samp_width != '0) && (samp_width < samp_period);
  assign w_continue = en && !single_shot && w_legal;

  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_per_n        = r_per;
    w_wid_n        = r_wid;
    w_samp_clk_n   = r_samp_clk;
    w_conv_start_n = 1'b0;
    w_busy_n       = r_busy;
    w_cfg_err_n    = r_cfg_err;
    w_start        = 1'b0;

    case (r_state)
      IDLE: begin
        w_cfg_err_n  = !w_legal;
        w_samp_clk_n = 1'b0;
        w_busy_n     = 1'b0;
        w_cnt_n      = '0;
        if (en && w_legal && (!single_shot || trig)) w_start = 1'b1;
      end
      TRACK: begin
        w_cnt_n = r_cnt + ONE;
        if (r_cnt == r_wid - ONE) begin
          w_state_n      = HOLD;
          w_samp_clk_n   = 1'b0;
          w_conv_start_n = 1'b1;
        end
      end
      HOLD: begin
        w_cnt_n = r_cnt + ONE;
        // Frame end: back-to-back restart only for a still-valid continuous run
        if (r_cnt == r_per - ONE) begin
          if (w_continue) begin
            w_start = 1'b1;
          end else begin
            w_state_n = IDLE;
            w_busy_n  = 1'b0;
            w_cnt_n   = '0;
            if (en && !single_shot) w_cfg_err_n = 1'b1;
          end
        end
      end
      default: begin
        w_state_n    = IDLE;
        w_samp_clk_n = 1'b0;
        w_busy_n     = 1'b0;
        w_cnt_n      = '0;
      end
    endcase

    if (w_start) begin
      w_state_n    = TRACK;
      w_cnt_n      = '0;
      w_per_n      = samp_period;
      w_wid_n      = samp_width;
      w_samp_clk_n = 1'b1;
      w_busy_n     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_per        <= '0;
      r_wid        <= '0;
      r_samp_clk   <= 1'b0;
      r_conv_start <= 1'b0;
      r_busy       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_per        <= w_per_n;
      r_wid        <= w_wid_n;
      r_samp_clk   <= w_samp_clk_n;
      r_conv_start <= w_conv_start_n;
      r_busy       <= w_busy_n;
      r_cfg_err    <= w_cfg_err_n;
    end
  end

  assign samp_clk   = r_samp_clk;
  assign conv_start = r_conv_start;
  assign busy       = r_busy;
  assign cfg_err    = r_cfg_err;

`ifdef SAMP_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst)                 r_frame_cnt <= '0;
    else if (w_conv_start_n) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
